// File: rtl/ssd_capture_pkg.sv
// ssd_pkg: shared constants for the seven-segment capture path.
//   SEG_N_0..SEG_N_9, SEG_N_BLANK : active-low segment patterns (bit0=a .. bit6=g)
//   SEG_A..SEG_G                  : segment bit positions within a pattern
//   ERR_CNT_W                     : width of the saturating error counter
//   pat_class_e                   : classification of a committed pattern
package ssd_pkg;

  localparam logic [6:0] SEG_N_0     = 7'h40;
  localparam logic [6:0] SEG_N_1     = 7'h79;
  localparam logic [6:0] SEG_N_2     = 7'h24;
  localparam logic [6:0] SEG_N_3     = 7'h30;
  localparam logic [6:0] SEG_N_4     = 7'h19;
  localparam logic [6:0] SEG_N_5     = 7'h12;
  localparam logic [6:0] SEG_N_6     = 7'h02;
  localparam logic [6:0] SEG_N_7     = 7'h78;
  localparam logic [6:0] SEG_N_8     = 7'h00;
  localparam logic [6:0] SEG_N_9     = 7'h10;
  localparam logic [6:0] SEG_N_BLANK = 7'h7F;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam int unsigned ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    PAT_DIGIT,
    PAT_BLANK,
    PAT_ILLEGAL
  } pat_class_e;

endpackage

// File: rtl/ssd_capture_if.sv
// ssd_capture_if: display bus plus decoded results.
//   seg_n       : active-low segments (bit0=a .. bit6=g)
//   dig_n       : active-low digit enables, bit i low selects digit i
//   value       : decoded BCD, digit i in bits [4i+3:4i]
//   digit_valid : digit i holds a legal decoded value
//   upd, err    : one-cycle pulses on a result change / illegal pattern
//   err_cnt     : saturating count of err pulses
// master drives the display bus; slave is the capture block.
interface ssd_capture_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  import ssd_pkg::*;

  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   dig_n;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    upd;
  logic                    err;
  logic [ERR_CNT_W-1:0]    err_cnt;

  modport master (
    output seg_n, dig_n,
    input  value, digit_valid, upd, err, err_cnt
  );

  modport slave (
    input  seg_n, dig_n,
    output value, digit_valid, upd, err, err_cnt
  );

endinterface

// File: rtl/ssd_capture_decode.sv
// ssd_decode: combinational active-low segment pattern to BCD decoder.
//   seg_n : active-low segment pattern
//   code  : BCD value (0 unless legal)
//   legal : pattern is one of the digits 0..9
//   blank : pattern has every segment off
module ssd_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] code,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    code  = '0;
    legal = 1'b1;
    blank = 1'b0;
    case (seg_n)
      SEG_N_0:     code = 4'd0;
      SEG_N_1:     code = 4'd1;
      SEG_N_2:     code = 4'd2;
      SEG_N_3:     code = 4'd3;
      SEG_N_4:     code = 4'd4;
      SEG_N_5:     code = 4'd5;
      SEG_N_6:     code = 4'd6;
      SEG_N_7:     code = 4'd7;
      SEG_N_8:     code = 4'd8;
      SEG_N_9:     code = 4'd9;
      SEG_N_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:     legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_capture.sv
// ssd_capture: reads a multiplexed active-low seven-segment bus back into
// per-digit BCD values. Each sampled {seg_n, dig_n} pair must be seen on
// STABLE_CYCLES consecutive edges with exactly one digit selected before it
// is committed to that digit; idle and ghosted selects reset the filter.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ssd_capture_if slave (seg_n/dig_n in, decoded results out)
module ssd_capture
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  ssd_capture_if.slave  bus
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [6:0]                 seg_q;
  logic [NUM_DIGITS-1:0]      dig_q;
  logic [CW-1:0]              cnt, cnt_nxt;
  logic                       commit_q, commit_nxt;
  logic [NUM_DIGITS-1:0][3:0] value_q;
  logic [NUM_DIGITS-1:0]      valid_q;
  logic                       upd_q, upd_nxt;
  logic                       err_q, err_nxt;
  logic [ERR_CNT_W-1:0]       err_cnt_q;

  logic       sel_now, same_now;
  logic [3:0] dec_code;
  logic       dec_legal, dec_blank;
  pat_class_e cls;
  logic [3:0] cur_val;
  logic       cur_valid;

  assign sel_now  = $onehot(~bus.dig_n);
  assign same_now = (bus.seg_n == seg_q) && (bus.dig_n == dig_q);

  // commit_nxt marks the edge on which the run length first reaches
  // CNT_MAX; the commit itself happens one edge later from seg_q/dig_q,
  // which at that point still hold the counted pair.
  always_comb begin
    cnt_nxt    = '0;
    commit_nxt = 1'b0;
    if (sel_now) begin
      if (same_now) begin
        cnt_nxt    = (cnt == CNT_MAX) ? CNT_MAX : cnt + CW'(1);
        commit_nxt = (cnt != CNT_MAX) && (cnt_nxt == CNT_MAX);
      end else begin
        cnt_nxt    = CW'(1);
        commit_nxt = (CNT_MAX == CW'(1));
      end
    end
  end

  ssd_decode u_decode (
    .seg_n (seg_q),
    .code  (dec_code),
    .legal (dec_legal),
    .blank (dec_blank)
  );

  always_comb begin
    if (dec_legal)      cls = PAT_DIGIT;
    else if (dec_blank) cls = PAT_BLANK;
    else                cls = PAT_ILLEGAL;
  end

  // Current contents of the digit addressed by dig_q (exactly one zero
  // whenever commit_q is set).
  always_comb begin
    cur_val   = '0;
    cur_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!dig_q[i]) begin
        cur_val   = value_q[i];
        cur_valid = valid_q[i];
      end
    end
  end

  always_comb begin
    upd_nxt = 1'b0;
    err_nxt = 1'b0;
    if (commit_q) begin
      case (cls)
        PAT_DIGIT: upd_nxt = !cur_valid || (cur_val != dec_code);
        PAT_BLANK: upd_nxt = cur_valid;
        default:   err_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q     <= SEG_N_BLANK;
      dig_q     <= '1;
      cnt       <= '0;
      commit_q  <= 1'b0;
      value_q   <= '0;
      valid_q   <= '0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      seg_q    <= bus.seg_n;
      dig_q    <= bus.dig_n;
      cnt      <= cnt_nxt;
      commit_q <= commit_nxt;
      upd_q    <= upd_nxt;
      err_q    <= err_nxt;
      if (commit_q) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (!dig_q[i]) begin
            if (cls == PAT_DIGIT) begin
              value_q[i] <= dec_code;
              valid_q[i] <= 1'b1;
            end else if (cls == PAT_BLANK) begin
              valid_q[i] <= 1'b0;
            end
          end
        end
      end
      if (err_nxt && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign bus.value       = value_q;
  assign bus.digit_valid = valid_q;
  assign bus.upd         = upd_q;
  assign bus.err         = err_q;
  assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_ssd_capture.sv
// tb_ssd_capture: directed scenarios followed by randomized display traffic,
// every cycle compared against a run-length reference model of the reader.
module tb_ssd_capture;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 4;

  localparam logic [6:0] SEG_TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic clk = 1'b0;
  logic rst = 1'b0;

  ssd_capture_if #(.NUM_DIGITS(ND)) bus ();

  ssd_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int upd_seen = 0;
  int err_seen = 0;

  // reference model state
  int         mval   [ND];
  bit         mvalid [ND];
  int         merr;
  int         run;
  bit         pend;
  logic [6:0] last_seg;
  logic [3:0] last_dig;
  bit         exp_upd;
  bit         exp_err;

  // 0..9 digit, 10 blank, -1 illegal
  function automatic int dec(input logic [6:0] p);
    if (p == 7'h7F) return 10;
    for (int k = 0; k < 10; k++)
      if (SEG_TBL[k] == p) return k;
    return -1;
  endfunction

  function automatic int zero_count(input logic [3:0] d);
    int n = 0;
    for (int k = 0; k < ND; k++) if (d[k] == 1'b0) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ND; k++) begin
      mval[k]   = 0;
      mvalid[k] = 1'b0;
    end
    merr     = 0;
    run      = 0;
    pend     = 1'b0;
    last_seg = 7'h7F;
    last_dig = 4'hF;
    exp_upd  = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic model_edge(input logic [6:0] s, input logic [3:0] d);
    int idx, v;
    exp_upd = 1'b0;
    exp_err = 1'b0;
    if (pend) begin
      idx = 0;
      for (int k = 0; k < ND; k++) if (last_dig[k] == 1'b0) idx = k;
      v = dec(last_seg);
      if (v >= 0 && v <= 9) begin
        if (!mvalid[idx] || mval[idx] != v) exp_upd = 1'b1;
        mval[idx]   = v;
        mvalid[idx] = 1'b1;
      end else if (v == 10) begin
        if (mvalid[idx]) exp_upd = 1'b1;
        mvalid[idx] = 1'b0;
      end else begin
        exp_err = 1'b1;
        if (merr < 255) merr++;
      end
    end
    if (zero_count(d) == 1) run = (s == last_seg && d == last_dig) ? run + 1 : 1;
    else run = 0;
    pend     = (run == SC);
    last_seg = s;
    last_dig = d;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] ev;
    logic [3:0]  evld;
    for (int k = 0; k < ND; k++) begin
      ev[4*k +: 4] = 4'(mval[k]);
      evld[k]      = mvalid[k];
    end
    check({tag, ".value"}, 32'(bus.value), 32'(ev));
    check({tag, ".valid"}, 32'(bus.digit_valid), 32'(evld));
    check({tag, ".upd"}, 32'(bus.upd), 32'(exp_upd));
    check({tag, ".err"}, 32'(bus.err), 32'(exp_err));
    check({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'(merr));
  endtask

  task automatic cyc(input string tag, input logic [6:0] s, input logic [3:0] d);
    bus.seg_n = s;
    bus.dig_n = d;
    @(posedge clk);
    #1;
    model_edge(s, d);
    if (bus.upd === 1'b1) upd_seen++;
    if (bus.err === 1'b1) err_seen++;
    check_all(tag);
  endtask

  // called #1 after a rising edge; release lands on the next falling edge
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] s;
    logic [3:0] d;
    int hold;

    bus.seg_n = 7'h7F;
    bus.dig_n = 4'hF;
    rst = 1'b1;
    model_reset();
    #2 check_all("por");
    @(negedge clk);
    rst = 1'b0;

    // reset in the middle of a run, then a full run from scratch
    repeat (3) cyc("pre_rst", 7'h12, 4'b1110);
    async_reset("mid_rst");
    repeat (5) cyc("post_rst", 7'h12, 4'b1110);
    check("rst_run.digit0", 32'(bus.value[3:0]), 32'd5);
    check("rst_run.upd", 32'(bus.upd), 32'd1);
    cyc("post_rst", 7'h12, 4'b1110);

    // scan all digits twice
    upd_seen = 0;
    for (int k = 0; k < 4; k++)
      repeat (6) cyc("scan", SEG_TBL[k+1], ~(4'b0001 << k));
    check("scan.value", 32'(bus.value), 32'h4321);
    check("scan.valid", 32'(bus.digit_valid), 32'hF);
    check("scan.upd_pulses", 32'(upd_seen), 32'd4);
    upd_seen = 0;
    for (int k = 0; k < 4; k++)
      repeat (6) cyc("rescan", SEG_TBL[k+1], ~(4'b0001 << k));
    check("rescan.upd_pulses", 32'(upd_seen), 32'd0);

    // glitch filter on digit 2
    async_reset("pre_glitch_rst");
    repeat (3) cyc("glitch", 7'h02, 4'b1011);
    cyc("glitch", 7'h03, 4'b1011);
    repeat (3) cyc("glitch", 7'h02, 4'b1011);
    check("glitch.valid2", 32'(bus.digit_valid[2]), 32'd0);
    repeat (2) cyc("glitch_hold", 7'h02, 4'b1011);
    check("glitch.digit2", 32'(bus.value[11:8]), 32'd6);
    check("glitch.valid2_set", 32'(bus.digit_valid[2]), 32'd1);

    // ghosting and idle never commit
    upd_seen = 0;
    err_seen = 0;
    repeat (20) cyc("ghost", 7'h00, 4'b1100);
    repeat (20) cyc("idle", 7'h00, 4'b1111);
    check("ghost_idle.upd_pulses", 32'(upd_seen), 32'd0);
    check("ghost_idle.err_pulses", 32'(err_seen), 32'd0);

    // blank then illegal on digit 1
    repeat (5) cyc("d1_seven", 7'h78, 4'b1101);
    upd_seen = 0;
    repeat (5) cyc("d1_blank", 7'h7F, 4'b1101);
    check("blank.valid1", 32'(bus.digit_valid[1]), 32'd0);
    check("blank.digit1_kept", 32'(bus.value[7:4]), 32'd7);
    check("blank.upd_pulses", 32'(upd_seen), 32'd1);
    err_seen = 0;
    repeat (5) cyc("d1_illegal", 7'h55, 4'b1101);
    check("illegal.err_pulses", 32'(err_seen), 32'd1);
    check("illegal.err_cnt", 32'(bus.err_cnt), 32'd1);

    // err_cnt saturation
    for (int r = 0; r < 300; r++)
      repeat (4) cyc("sat", (r % 2 == 0) ? 7'h55 : 7'h2A, 4'b1110);
    cyc("sat_tail", 7'h7F, 4'b1111);
    check("sat.err_cnt", 32'(bus.err_cnt), 32'd255);

    // randomized traffic
    for (int r = 0; r < 250; r++) begin
      case ($urandom_range(0, 9))
        0:       d = 4'hF;
        1:       d = 4'($urandom);
        default: d = ~(4'b0001 << $urandom_range(0, ND - 1));
      endcase
      case ($urandom_range(0, 7))
        0:       s = 7'h7F;
        1, 2:    s = 7'($urandom);
        default: s = SEG_TBL[$urandom_range(0, 9)];
      endcase
      hold = $urandom_range(1, 7);
      repeat (hold) cyc("rand", s, d);
    end

    async_reset("final_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
